fila_escrita_registradores: RTL and testbench

//   Write-side initiator for the 32x32 register file. Buffers writeback requests

---
 rtl/fila_escrita_registradores_if.sv | 33 +++
 rtl/fila_escrita_registradores.sv | 113 +++++++++++
 tb/tb_fila_escrita_registradores.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fila_escrita_registradores_if.sv
// Writeback queue bus: push handshake, register-file write port, bypass lookups and occupancy.
// slave = queue side, master = producer / register-file / decode side.
interface fila_escrita_registradores_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          InValid;
  logic          InReady;
  logic [4:0]    InReg;
  logic [31:0]   InDado;
  logic          Hold;
  logic          WriteReg;
  logic [4:0]    EscreveReg;
  logic [31:0]   EscreveDado;
  logic [4:0]    LeReg1;
  logic [4:0]    LeReg2;
  logic          Hit1;
  logic          Hit2;
  logic [31:0]   Fwd1;
  logic [31:0]   Fwd2;
  logic [CW-1:0] Count;

  modport slave (
    input  InValid, InReg, InDado, Hold, LeReg1, LeReg2,
    output InReady, WriteReg, EscreveReg, EscreveDado, Hit1, Hit2, Fwd1, Fwd2, Count
  );

  modport master (
    output InValid, InReg, InDado, Hold, LeReg1, LeReg2,
    input  InReady, WriteReg, EscreveReg, EscreveDado, Hit1, Hit2, Fwd1, Fwd2, Count
  );
endinterface

// File: rtl/fila_escrita_registradores.sv
// Writeback queue draining one entry per cycle into the register file, with two bypass ports.
// Optional macro WB_COALESCE_EN: a push matching the youngest entry's register overwrites it.
module fila_escrita_registradores #(
  parameter int unsigned DEPTH = 4
) (
  input logic                         Clock,
  input logic                         Reset,
  fila_escrita_registradores_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]    r_reg  [DEPTH];
  logic [31:0]   r_dado [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_coal;
  logic w_alloc;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  // A reset cycle must never strobe the register file.
  assign w_pop   = !w_empty && !bus.Hold && !Reset;
  // Writes to r0 complete the handshake but are dropped.
  assign w_push  = bus.InValid && !w_full && (bus.InReg != 5'd0);

`ifdef WB_COALESCE_EN
  logic [PW-1:0] w_young;
  assign w_young = r_tail - PW'(1);
  // A lone head leaving this cycle cannot absorb the push; it enqueues behind it instead.
  assign w_coal  = w_push && !w_empty && (r_reg[w_young] == bus.InReg)
                   && !(w_pop && (r_count == CW'(1)));
`else
  assign w_coal  = 1'b0;
`endif

  assign w_alloc = w_push && !w_coal;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
    end
  end

  // Payload storage needs no reset: validity comes from head/count alone.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (w_alloc) begin
        r_reg[r_tail]  <= bus.InReg;
        r_dado[r_tail] <= bus.InDado;
      end
`ifdef WB_COALESCE_EN
      if (w_coal) begin
        r_dado[w_young] <= bus.InDado;
      end
`endif
    end
  end

  logic          w_hit1;
  logic          w_hit2;
  logic [31:0]   w_fwd1;
  logic [31:0]   w_fwd2;
  logic [PW-1:0] w_idx;

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_fwd1 = '0;
    w_fwd2 = '0;
    w_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if (CW'(k) < r_count) begin
        if ((bus.LeReg1 != 5'd0) && (r_reg[w_idx] == bus.LeReg1)) begin
          w_hit1 = 1'b1;
          w_fwd1 = r_dado[w_idx];
        end
        if ((bus.LeReg2 != 5'd0) && (r_reg[w_idx] == bus.LeReg2)) begin
          w_hit2 = 1'b1;
          w_fwd2 = r_dado[w_idx];
        end
      end
    end
  end

  assign bus.InReady     = !w_full;
  assign bus.WriteReg    = w_pop;
  assign bus.EscreveReg  = w_empty ? 5'd0  : r_reg[r_head];
  assign bus.EscreveDado = w_empty ? 32'd0 : r_dado[r_head];
  assign bus.Hit1        = w_hit1;
  assign bus.Hit2        = w_hit2;
  assign bus.Fwd1        = w_fwd1;
  assign bus.Fwd2        = w_fwd2;
  assign bus.Count       = r_count;
endmodule

// File: tb/tb_fila_escrita_registradores.sv
// Bench for the writeback queue: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based reference model.
module tb_fila_escrita_registradores;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  fila_escrita_registradores_if #(.DEPTH(DEPTH)) bus ();

  fila_escrita_registradores #(.DEPTH(DEPTH)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t q[$];
  bit   model_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the rules to the pending-write list for the inputs about to be sampled.
  task automatic model_step();
    bit   pop;
    bit   push;
    bit   coal;
    ent_t e;
    if (Reset) begin
      q.delete();
      model_ok = 1'b1;
      return;
    end
    if (!model_ok) return;
    pop  = (q.size() != 0) && !bus.Hold;
    push = bus.InValid && (q.size() < DEPTH) && (bus.InReg != 5'd0);
    coal = 1'b0;
`ifdef WB_COALESCE_EN
    if (push && q.size() != 0 && q[q.size()-1].r == bus.InReg && !(pop && q.size() == 1))
      coal = 1'b1;
`endif
    if (coal) begin
      e = q[q.size()-1];
      e.d = bus.InDado;
      q[q.size()-1] = e;
    end
    if (pop) void'(q.pop_front());
    if (push && !coal) begin
      e.r = bus.InReg;
      e.d = bus.InDado;
      q.push_back(e);
    end
  endtask

  // Inputs are settled by the falling edge; model advances, then the rising edge commits.
  task automatic cyc();
    @(negedge Clock);
    #1;
    model_step();
    @(posedge Clock);
    #2;
  endtask

  task automatic compare();
    int          n;
    logic        h1;
    logic        h2;
    logic [31:0] f1;
    logic [31:0] f2;
    n  = q.size();
    h1 = 1'b0;
    h2 = 1'b0;
    f1 = 32'd0;
    f2 = 32'd0;
    for (int i = 0; i < n; i++) begin
      if (bus.LeReg1 != 5'd0 && q[i].r == bus.LeReg1) begin h1 = 1'b1; f1 = q[i].d; end
      if (bus.LeReg2 != 5'd0 && q[i].r == bus.LeReg2) begin h2 = 1'b1; f2 = q[i].d; end
    end
    chk("count",   32'(bus.Count),    32'(n));
    chk("inready", 32'(bus.InReady),  32'(n < DEPTH));
    chk("wreg",    32'(bus.WriteReg), 32'(n != 0 && !bus.Hold && !Reset));
    chk("ereg",    32'(bus.EscreveReg),  (n != 0) ? 32'(q[0].r) : 32'd0);
    chk("edado",   bus.EscreveDado,      (n != 0) ? q[0].d : 32'd0);
    chk("hit1",    32'(bus.Hit1), 32'(h1));
    chk("fwd1",    bus.Fwd1, f1);
    chk("hit2",    32'(bus.Hit2), 32'(h2));
    chk("fwd2",    bus.Fwd2, f2);
  endtask

  always @(negedge Clock) begin
    if (model_ok) compare();
  end

  task automatic push_in(input logic [4:0] r, input logic [31:0] d);
    bus.InValid = 1'b1;
    bus.InReg   = r;
    bus.InDado  = d;
    cyc();
    bus.InValid = 1'b0;
  endtask

  initial begin
    bus.InValid = 1'b0;
    bus.InReg   = 5'd0;
    bus.InDado  = 32'd0;
    bus.Hold    = 1'b0;
    bus.LeReg1  = 5'd0;
    bus.LeReg2  = 5'd0;
    Reset       = 1'b1;
    cyc();
    Reset = 1'b0;
    #1;
    chk("rst_count",   32'(bus.Count), 32'd0);
    chk("rst_inready", 32'(bus.InReady), 32'd1);
    chk("rst_wreg",    32'(bus.WriteReg), 32'd0);
    chk("rst_ereg",    32'(bus.EscreveReg), 32'd0);

    // Single push drains on the next edge.
    push_in(5'd8, 32'hAAAA_0001);
    #1;
    chk("t1_wreg",  32'(bus.WriteReg), 32'd1);
    chk("t1_ereg",  32'(bus.EscreveReg), 32'd8);
    chk("t1_edado", bus.EscreveDado, 32'hAAAA_0001);
    cyc();
    #1;
    chk("t1_count_after", 32'(bus.Count), 32'd0);
    chk("t1_wreg_after",  32'(bus.WriteReg), 32'd0);

    // Fill while held, overflow push ignored, then in-order drain.
    bus.Hold = 1'b1;
    for (int i = 1; i <= 4; i++) push_in(5'(i), 32'h100 + 32'(i));
    #1;
    chk("t2_count_full", 32'(bus.Count), 32'd4);
    chk("t2_inready",    32'(bus.InReady), 32'd0);
    push_in(5'd5, 32'h55);
    #1;
    chk("t2_count_ovf", 32'(bus.Count), 32'd4);
    bus.Hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t2_wreg",  32'(bus.WriteReg), 32'd1);
      chk("t2_ereg",  32'(bus.EscreveReg), 32'(i));
      chk("t2_edado", bus.EscreveDado, 32'h100 + 32'(i));
      cyc();
    end
    #1;
    chk("t2_count_empty", 32'(bus.Count), 32'd0);

    // Bypass returns the youngest match.
    bus.Hold = 1'b1;
    push_in(5'd5, 32'd10);
    push_in(5'd5, 32'd20);
    bus.LeReg1 = 5'd5;
    bus.LeReg2 = 5'd6;
    #1;
    chk("t3_hit1", 32'(bus.Hit1), 32'd1);
    chk("t3_fwd1", bus.Fwd1, 32'd20);
    chk("t3_hit2", 32'(bus.Hit2), 32'd0);
    chk("t3_fwd2", bus.Fwd2, 32'd0);
    bus.Hold   = 1'b0;
    bus.LeReg1 = 5'd0;
    bus.LeReg2 = 5'd0;
    repeat (3) cyc();

    // Push to r0 completes but stores nothing.
    bus.InValid = 1'b1;
    bus.InReg   = 5'd0;
    bus.InDado  = 32'hFFFF_FFFF;
    #1;
    chk("t4_inready", 32'(bus.InReady), 32'd1);
    cyc();
    bus.InValid = 1'b0;
    #1;
    chk("t4_count", 32'(bus.Count), 32'd0);
    chk("t4_wreg",  32'(bus.WriteReg), 32'd0);

    // Reset mid-drain discards everything and writes nothing.
    bus.Hold = 1'b1;
    push_in(5'd10, 32'hA);
    push_in(5'd11, 32'hB);
    push_in(5'd12, 32'hC);
    bus.Hold = 1'b0;
    Reset    = 1'b1;
    #1;
    chk("t5_wreg_in_rst", 32'(bus.WriteReg), 32'd0);
    cyc();
    Reset = 1'b0;
    #1;
    chk("t5_count", 32'(bus.Count), 32'd0);
    chk("t5_wreg",  32'(bus.WriteReg), 32'd0);
    cyc();
    #1;
    chk("t5_wreg_later", 32'(bus.WriteReg), 32'd0);

    // Same-register pushes: coalesced only with the macro.
    bus.Hold = 1'b1;
    push_in(5'd9, 32'd1);
    push_in(5'd9, 32'd2);
    bus.LeReg1 = 5'd9;
    #1;
`ifdef WB_COALESCE_EN
    chk("t6_count", 32'(bus.Count), 32'd1);
`else
    chk("t6_count", 32'(bus.Count), 32'd2);
`endif
    chk("t6_hit1", 32'(bus.Hit1), 32'd1);
    chk("t6_fwd1", bus.Fwd1, 32'd2);
    bus.Hold   = 1'b0;
    bus.LeReg1 = 5'd0;
    repeat (3) cyc();

    // Random traffic; hold pressure alternates so the queue both fills and drains.
    for (int c = 0; c < 3000; c++) begin
      Reset       = ($urandom_range(0, 149) == 0);
      bus.InValid = ($urandom_range(0, 3) != 0);
      bus.InReg   = 5'($urandom_range(0, 7));
      bus.InDado  = $urandom;
      bus.Hold    = (((c / 150) % 2) == 0) ? ($urandom_range(0, 9) < 7)
                                           : ($urandom_range(0, 9) < 2);
      bus.LeReg1  = 5'($urandom_range(0, 7));
      bus.LeReg2  = 5'($urandom_range(0, 7));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
